// File: rtl/seal_trig_dev.sv
// Memory-mapped trigger/marker responder: capture trigger, triggered-cycle counter, marker FIFO.
// Optional marker FIFO enabled by defining SEAL_TRIG_FIFO_EN; without it MARKER errors and STATUS reads empty.
module seal_trig_dev #(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned CntWidth  = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        trigger_o,
    output logic        marker_valid_o,
    output logic [31:0] marker_data_o,
    input  logic        marker_ready_i
);

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_CYCLES = 8'h01;
    localparam logic [7:0] REG_MARKER = 8'h02;
    localparam logic [7:0] REG_STATUS = 8'h03;

    logic [7:0]          word_idx;
    logic                wr_ctrl;
    logic                ctrl_clr;
    logic                trig_q;
    logic [CntWidth-1:0] cycles_q;
    logic [31:0]         status_word;
    logic [31:0]         rd_data;
    logic                dec_err;

    assign word_idx  = addr_i[9:2];
    assign wr_ctrl   = req_i && we_i && (word_idx == REG_CTRL) && be_i[0];
    assign ctrl_clr  = wr_ctrl && wdata_i[1];
    assign trigger_o = trig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            if (wr_ctrl) trig_q <= wdata_i[0];
            // CLR wins over counting, so CLR+TRIG restarts from 0 on the following cycle.
            if (ctrl_clr)    cycles_q <= '0;
            else if (trig_q) cycles_q <= cycles_q + CntWidth'(1);
        end
    end

`ifdef SEAL_TRIG_FIFO_EN
    localparam int unsigned AW = $clog2(FifoDepth);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem [FifoDepth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow_q;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          ovf_clr;
    logic          unused_bits;

    assign full     = (count == CW'(FifoDepth));
    assign empty    = (count == '0);
    assign push_req = req_i && we_i && (word_idx == REG_MARKER) && (be_i == 4'hF);
    assign do_pop   = !empty && marker_ready_i;
    assign do_push  = push_req && (!full || do_pop);
    assign ovf_clr  = req_i && we_i && (word_idx == REG_STATUS) && be_i[1] && wdata_i[10];

    assign marker_valid_o = !empty;
    assign marker_data_o  = empty ? 32'h0 : mem[rd_ptr];
    assign status_word    = {21'h0, overflow_q, empty, full, 8'(count)};
    assign unused_bits    = ^{addr_i[31:10], addr_i[1:0]};

    // NOTE: storage has no reset; the empty count masks stale contents, so no reset tree is needed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && full && !do_pop) overflow_q <= 1'b1;
            else if (ovf_clr)                overflow_q <= 1'b0;
        end
    end
`else
    logic unused_bits;

    assign marker_valid_o = 1'b0;
    assign marker_data_o  = 32'h0;
    assign status_word    = 32'h0000_0200;
    assign unused_bits    = ^{addr_i[31:10], addr_i[1:0], wdata_i[31:2], be_i[3:1], marker_ready_i};
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_data = 32'h0;
        dec_err = 1'b0;
        case (word_idx)
            REG_CTRL:   rd_data = {31'h0, trig_q};
            REG_CYCLES: begin
                rd_data = 32'(cycles_q);
                dec_err = we_i;
            end
`ifdef SEAL_TRIG_FIFO_EN
            REG_MARKER: dec_err = !we_i || (be_i != 4'hF);
`else
            REG_MARKER: dec_err = 1'b1;
`endif
            REG_STATUS: rd_data = status_word;
            default:    dec_err = 1'b1;
        endcase
    end

    // Response is registered from request-edge state, so reads see pre-update values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= 32'h0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i && dec_err;
            rdata_o  <= (req_i && !we_i && !dec_err) ? rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_seal_trig_dev.sv
// Directed self-checking bench for seal_trig_dev; FIFO steps follow SEAL_TRIG_FIFO_EN.
module tb_seal_trig_dev;

    localparam logic [31:0] A_CTRL   = 32'h0004_0000;
    localparam logic [31:0] A_CYCLES = 32'h0004_0004;
    localparam logic [31:0] A_MARKER = 32'h0004_0008;
    localparam logic [31:0] A_STATUS = 32'h0004_000C;
    localparam logic [31:0] A_BAD    = 32'h0004_0010;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        trigger_o;
    logic        marker_valid_o;
    logic [31:0] marker_data_o;
    logic        marker_ready_i;

    int          checks = 0;
    int          passes = 0;
    int          hi_cycles;
    logic        rv;
    logic        er;
    logic [31:0] rd;

    seal_trig_dev #(.FifoDepth(8), .CntWidth(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .we_i           (we_i),
        .be_i           (be_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .trigger_o      (trigger_o),
        .marker_valid_o (marker_valid_o),
        .marker_data_o  (marker_data_o),
        .marker_ready_i (marker_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus transaction: accepted at the next edge, response sampled 1 ns later.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        be_i    = be;
        wdata_i = wd;
        @(posedge clk_i);
        #1;
        rv      = rvalid_o;
        rd      = rdata_o;
        er      = err_o;
        req_i   = 1'b0;
        we_i    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pop();
        marker_ready_i = 1'b1;
        step();
        marker_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
        addr_i = 32'h0; wdata_i = 32'h0; marker_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        check("rst_trigger", trigger_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_mvalid", marker_valid_o, 0);
        check("rst_mdata", marker_data_o, 0);

        bus(0, A_CTRL, 4'hF, 0);
        check("rd_ctrl_rvalid", rv, 1);
        check("rd_ctrl_data", rd, 0);
        check("rd_ctrl_err", er, 0);
        step();
        check("rvalid_pulse", rvalid_o, 0);
        bus(0, A_CYCLES, 4'hF, 0);
        check("rd_cycles_data", rd, 0);
        check("rd_cycles_err", er, 0);
        bus(0, A_STATUS, 4'hF, 0);
        check("rd_status_rvalid", rv, 1);
        check("rd_status_data", rd, 32'h200);
        check("rd_status_err", er, 0);
        bus(0, A_BAD, 4'hF, 0);
        check("rd_bad_err", er, 1);
        check("rd_bad_data", rd, 0);

        // Triggered window: 101 high cycles, CYCLES counts 101.
        bus(1, A_CTRL, 4'hF, 32'h1);
        check("wr_ctrl_rvalid", rv, 1);
        check("wr_ctrl_err", er, 0);
        hi_cycles = trigger_o ? 1 : 0;
        repeat (100) begin
            step();
            if (trigger_o) hi_cycles++;
        end
        bus(1, A_CTRL, 4'hF, 32'h0);
        check("trig_fall", trigger_o, 0);
        check("trig_hi_cycles", hi_cycles, 101);
        bus(0, A_CYCLES, 4'hF, 0);
        check("cycles_101", rd, 32'd101);
        bus(1, A_CTRL, 4'hF, 32'h2);
        bus(0, A_CYCLES, 4'hF, 0);
        check("cycles_clr", rd, 0);

        bus(1, A_CTRL, 4'hE, 32'h1);
        check("ctrl_be0_err", er, 0);
        check("ctrl_be0_trig", trigger_o, 0);
        bus(1, A_CYCLES, 4'hF, 32'h55);
        check("wr_cycles_err", er, 1);
        check("wr_cycles_data", rd, 0);
        bus(0, A_CYCLES, 4'hF, 0);
        check("wr_cycles_nochg", rd, 0);

        // CLR and TRIG together: 0 next cycle, then counts.
        bus(1, A_CTRL, 4'hF, 32'h3);
        bus(0, A_CYCLES, 4'hF, 0);
        check("clrtrig_c0", rd, 0);
        bus(0, A_CYCLES, 4'hF, 0);
        check("clrtrig_c1", rd, 1);
        bus(0, A_CTRL, 4'hF, 0);
        check("ctrl_clr_reads0", rd, 1);
        bus(1, A_CTRL, 4'hF, 32'h2);
        check("trig_off", trigger_o, 0);

`ifdef SEAL_TRIG_FIFO_EN
        for (int i = 1; i <= 9; i++) begin
            bus(1, A_MARKER, 4'hF, 32'hA5A5_0000 + 32'(i));
            check("push_err", er, 0);
        end
        bus(0, A_STATUS, 4'hF, 0);
        check("status_full_ovf", rd, 32'h508);
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", marker_valid_o, 1);
            check("drain_data", marker_data_o, 32'hA5A5_0000 + 32'(i));
            pop();
        end
        check("drained_valid", marker_valid_o, 0);
        check("drained_data", marker_data_o, 0);
        bus(0, A_STATUS, 4'hF, 0);
        check("status_empty_ovf", rd, 32'h600);
        bus(1, A_STATUS, 4'hF, 32'h400);
        bus(0, A_STATUS, 4'hF, 0);
        check("status_ovf_clr", rd, 32'h200);

        marker_ready_i = 1'b1;
        bus(1, A_MARKER, 4'hF, 32'h1234);
        marker_ready_i = 1'b0;
        check("empty_pushpop_valid", marker_valid_o, 1);
        check("empty_pushpop_data", marker_data_o, 32'h1234);
        bus(0, A_STATUS, 4'hF, 0);
        check("empty_pushpop_cnt", rd, 32'h001);
        pop();
        check("single_popped", marker_valid_o, 0);

        for (int i = 1; i <= 8; i++) bus(1, A_MARKER, 4'hF, 32'hB000_0000 + 32'(i));
        bus(0, A_STATUS, 4'hF, 0);
        check("full8", rd, 32'h108);
        check("full_head", marker_data_o, 32'hB000_0001);
        marker_ready_i = 1'b1;
        bus(1, A_MARKER, 4'hF, 32'h0000_C0DE);
        marker_ready_i = 1'b0;
        check("full_pushpop_err", er, 0);
        bus(0, A_STATUS, 4'hF, 0);
        check("full_pushpop_cnt", rd, 32'h108);
        for (int i = 2; i <= 8; i++) begin
            check("full_drain", marker_data_o, 32'hB000_0000 + 32'(i));
            pop();
        end
        check("full_last", marker_data_o, 32'h0000_C0DE);
        pop();
        check("full_empty", marker_valid_o, 0);

        bus(1, A_MARKER, 4'h3, 32'hDEAD_BEEF);
        check("marker_be3_err", er, 1);
        check("marker_be3_valid", marker_valid_o, 0);
        bus(0, A_STATUS, 4'hF, 0);
        check("marker_be3_status", rd, 32'h200);
        bus(0, A_MARKER, 4'hF, 0);
        check("marker_rd_err", er, 1);

        bus(1, A_MARKER, 4'hF, 32'h7777_0000);
`else
        bus(1, A_MARKER, 4'hF, 32'hA5A5_0001);
        check("nofifo_marker_err", er, 1);
        check("nofifo_valid", marker_valid_o, 0);
        check("nofifo_data", marker_data_o, 0);
        bus(1, A_STATUS, 4'hF, 32'h400);
        check("nofifo_status_wr_err", er, 0);
        bus(0, A_STATUS, 4'hF, 0);
        check("nofifo_status", rd, 32'h200);
        bus(0, A_MARKER, 4'hF, 0);
        check("nofifo_marker_rd_err", er, 1);
        bus(1, A_MARKER, 4'h3, 32'h1);
        check("nofifo_marker_be3_err", er, 1);
`endif

        // Reset coincident with a read request drops the response and clears state.
        bus(1, A_CTRL, 4'hF, 32'h1);
        check("pre_rst_trig", trigger_o, 1);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = A_CTRL;
        rst_i  = 1'b1;
        step();
        rst_i  = 1'b0;
        req_i  = 1'b0;
        check("midrst_rvalid", rvalid_o, 0);
        check("midrst_trig", trigger_o, 0);
        check("midrst_mvalid", marker_valid_o, 0);
        bus(0, A_CYCLES, 4'hF, 0);
        check("midrst_cycles", rd, 0);
        bus(0, A_STATUS, 4'hF, 0);
        check("midrst_status", rd, 32'h200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
